// File: rtl/controle_pkg.sv
// Shared definitions for the multicycle control unit: instruction field
// constants, ALU operation codes, FSM state encoding and the control word
// that the decoder produces and the FSM latches in DECODE.
package controle_pkg;

   // Opcodes of the supported instruction groups
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_RTYPE = 7'b0110011;
   localparam logic [6:0] OPC_ITYPE = 7'b0010011;

   // funct3 values; ld and sd share the doubleword width code
   localparam logic [2:0] F3_LDSD = 3'b011;
   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SUBI = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_EQU  = 3'b100;

   // funct7 values for the R-type group
   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;

   // ALU operation select driven on op_ula
   typedef enum logic [1:0] {
      ULA_ADD = 2'b00,
      ULA_SUB = 2'b01,
      ULA_SLT = 2'b10,
      ULA_EQU = 2'b11
   } ula_op_t;

   // Sequencer states
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_EXEC,
      ST_MEM,
      ST_WB,
      ST_TRAP
   } estado_t;

   // Decoded control word; legal=0 marks an unsupported encoding
   typedef struct packed {
      ula_op_t op_ula;
      logic    ula_entry;
      logic    operation_type;
      logic    is_mem;
      logic    is_store;
      logic    legal;
   } ctrl_word_t;

   // Control word used for reset and for every unsupported encoding
   localparam ctrl_word_t CTRL_NOP = '{
      op_ula:         ULA_ADD,
      ula_entry:      1'b0,
      operation_type: 1'b0,
      is_mem:         1'b0,
      is_store:       1'b0,
      legal:          1'b0
   };

   // Builds a legal control word from its fields
   function automatic ctrl_word_t mk_ctrl(input ula_op_t op,
                                          input logic    entry,
                                          input logic    op_type,
                                          input logic    mem,
                                          input logic    store);
      ctrl_word_t c;
      c.op_ula         = op;
      c.ula_entry      = entry;
      c.operation_type = op_type;
      c.is_mem         = mem;
      c.is_store       = store;
      c.legal          = 1'b1;
      return c;
   endfunction

endpackage

// File: rtl/decodificador_instrucao.sv
// Combinational instruction decoder: splits the 32-bit instruction into
// opcode/funct3/funct7 and produces the control word for the sequencer.
// Register and immediate fields are consumed by the datapath, not here.
module decodificador_instrucao
   import controle_pkg::*;
(
   input  logic [31:0] i_instrucao,
   output ctrl_word_t  o_ctrl
);

   logic [6:0] w_opcode;
   logic [2:0] w_funct3;
   logic [6:0] w_funct7;
   logic       w_unused_campos;

   assign w_opcode        = i_instrucao[6:0];
   assign w_funct3        = i_instrucao[14:12];
   assign w_funct7        = i_instrucao[31:25];
   assign w_unused_campos = ^{i_instrucao[24:15], i_instrucao[11:7]};

   // Map each supported opcode/funct3/funct7 combination to its control
   // word; anything not listed falls through to the illegal NOP word.
   always_comb begin
      o_ctrl = CTRL_NOP;
      case (w_opcode)
         OPC_LOAD: begin
            if (w_funct3 == F3_LDSD)
               o_ctrl = mk_ctrl(ULA_ADD, 1'b0, 1'b0, 1'b1, 1'b0);
         end
         OPC_STORE: begin
            if (w_funct3 == F3_LDSD)
               o_ctrl = mk_ctrl(ULA_ADD, 1'b0, 1'b1, 1'b1, 1'b1);
         end
         OPC_RTYPE: begin
            if (w_funct7 == F7_BASE) begin
               case (w_funct3)
                  F3_ADD:  o_ctrl = mk_ctrl(ULA_ADD, 1'b1, 1'b1, 1'b0, 1'b0);
                  F3_SLT:  o_ctrl = mk_ctrl(ULA_SLT, 1'b1, 1'b1, 1'b0, 1'b0);
                  F3_EQU:  o_ctrl = mk_ctrl(ULA_EQU, 1'b1, 1'b1, 1'b0, 1'b0);
                  default: o_ctrl = CTRL_NOP;
               endcase
            end else if (w_funct7 == F7_SUB && w_funct3 == F3_ADD) begin
               o_ctrl = mk_ctrl(ULA_SUB, 1'b1, 1'b1, 1'b0, 1'b0);
            end
         end
         OPC_ITYPE: begin
            case (w_funct3)
               F3_ADD:  o_ctrl = mk_ctrl(ULA_ADD, 1'b0, 1'b1, 1'b0, 1'b0);
               F3_SUBI: o_ctrl = mk_ctrl(ULA_SUB, 1'b0, 1'b1, 1'b0, 1'b0);
               F3_SLT:  o_ctrl = mk_ctrl(ULA_SLT, 1'b0, 1'b1, 1'b0, 1'b0);
               default: o_ctrl = CTRL_NOP;
            endcase
         end
         default: o_ctrl = CTRL_NOP;
      endcase
   end

endmodule

// File: rtl/unidade_controle.sv
// Multicycle control unit. A single registered FSM walks each instruction
// through FETCH, DECODE, EXEC, MEM and WB, pulsing the datapath enables in
// the cycles they are needed. ALU controls come straight from the control
// word latched in DECODE, so they stay put until the next decode.
module unidade_controle #(
   parameter int CNT_BITS = 31
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic [31:0]       instrucao,
   output logic              ir_en,
   output logic              pc_en,
   output logic              load_en,
   output logic              store_en,
   output logic [1:0]        op_ula,
   output logic              operation_type,
   output logic              ula_entry,
   output logic              busy,
   output logic              illegal,
   output logic [CNT_BITS:0] retired
);

   import controle_pkg::*;

   estado_t           r_state;
   ctrl_word_t        r_ctrl;
   ctrl_word_t        w_ctrl;
   logic              r_ir_en;
   logic              r_pc_en;
   logic              r_load_en;
   logic              r_store_en;
   logic              r_busy;
   logic              r_illegal;
   logic [CNT_BITS:0] r_retired;
   logic              w_unused_legal;

   decodificador_instrucao u_decodificador (
      .i_instrucao (instrucao),
      .o_ctrl      (w_ctrl)
   );

   // Sequencer with registered outputs: every transition also sets the
   // enables that belong to the state being entered. Enables default low
   // so each one is a single-cycle pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_IDLE;
         r_ctrl     <= CTRL_NOP;
         r_ir_en    <= 1'b0;
         r_pc_en    <= 1'b0;
         r_load_en  <= 1'b0;
         r_store_en <= 1'b0;
         r_busy     <= 1'b0;
         r_illegal  <= 1'b0;
      end else begin
         r_ir_en    <= 1'b0;
         r_pc_en    <= 1'b0;
         r_load_en  <= 1'b0;
         r_store_en <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (start && !stop) begin
                  r_state <= ST_FETCH;
                  r_ir_en <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            ST_FETCH: begin
               r_state <= ST_DECODE;
            end
            ST_DECODE: begin
               r_ctrl <= w_ctrl;
               if (w_ctrl.legal) begin
                  r_state <= ST_EXEC;
               end else begin
                  r_state   <= ST_TRAP;
                  r_busy    <= 1'b0;
                  r_illegal <= 1'b1;
               end
            end
            ST_EXEC: begin
               if (r_ctrl.is_mem) begin
                  r_state <= ST_MEM;
                  if (r_ctrl.is_store) begin
                     r_store_en <= 1'b1;
                     r_pc_en    <= 1'b1;
                  end
               end else begin
                  r_state   <= ST_WB;
                  r_load_en <= 1'b1;
                  r_pc_en   <= 1'b1;
               end
            end
            ST_MEM: begin
               if (r_ctrl.is_store) begin
                  if (stop) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= ST_FETCH;
                     r_ir_en <= 1'b1;
                  end
               end else begin
                  r_state   <= ST_WB;
                  r_load_en <= 1'b1;
                  r_pc_en   <= 1'b1;
               end
            end
            ST_WB: begin
               if (stop) begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_state <= ST_FETCH;
                  r_ir_en <= 1'b1;
               end
            end
            ST_TRAP: begin
               r_state <= ST_TRAP;
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Retired-instruction counter: one count per pc_en pulse, free wrapping
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_retired <= '0;
      else if (r_pc_en)
         r_retired <= r_retired + {{CNT_BITS{1'b0}}, 1'b1};
   end

   assign w_unused_legal = r_ctrl.legal;

   assign ir_en          = r_ir_en;
   assign pc_en          = r_pc_en;
   assign load_en        = r_load_en;
   assign store_en       = r_store_en;
   assign op_ula         = r_ctrl.op_ula;
   assign operation_type = r_ctrl.operation_type;
   assign ula_entry      = r_ctrl.ula_entry;
   assign busy           = r_busy;
   assign illegal        = r_illegal;
   assign retired        = r_retired;

endmodule

// File: tb/tb_unidade_controle.sv
// Testbench for unidade_controle. Each issued instruction pushes its
// hand-computed completion record into a scoreboard queue; a monitor pops
// one record whenever the DUT pulses pc_en and compares the outputs.
// The counter is narrowed to 4 bits so the wrap case is reachable.
module tb_unidade_controle;

   localparam int CNT_BITS = 3;

   localparam logic [31:0] I_ADD  = 32'h002081B3;
   localparam logic [31:0] I_LD   = 32'h0080B283;
   localparam logic [31:0] I_SD   = 32'h00513823;
   localparam logic [31:0] I_SUB  = 32'h402081B3;
   localparam logic [31:0] I_SLT  = 32'h0020A1B3;
   localparam logic [31:0] I_EQU  = 32'h0020C1B3;
   localparam logic [31:0] I_ADDI = 32'h00108093;
   localparam logic [31:0] I_SUBI = 32'h00109093;
   localparam logic [31:0] I_SLTI = 32'h0010A093;

   logic              clk = 1'b0;
   logic              reset;
   logic              start;
   logic              stop;
   logic [31:0]       instrucao;
   logic              ir_en;
   logic              pc_en;
   logic              load_en;
   logic              store_en;
   logic [1:0]        op_ula;
   logic              operation_type;
   logic              ula_entry;
   logic              busy;
   logic              illegal;
   logic [CNT_BITS:0] retired;

   typedef struct {
      string             name;
      int                cycles;
      logic [1:0]        opUla;
      logic              ulaEntry;
      logic              opType;
      logic              isStore;
      logic [CNT_BITS:0] retiredBefore;
   } expT;

   expT               scoreboard[$];
   expT               monExp;
   int                compared = 0;
   int                mismatched = 0;
   logic [CNT_BITS:0] expRetired;
   int                monCycles = 0;
   int                monLoads = 0;
   int                monStores = 0;

   unidade_controle #(.CNT_BITS(CNT_BITS)) dut (
      .clk            (clk),
      .reset          (reset),
      .start          (start),
      .stop           (stop),
      .instrucao      (instrucao),
      .ir_en          (ir_en),
      .pc_en          (pc_en),
      .load_en        (load_en),
      .store_en       (store_en),
      .op_ula         (op_ula),
      .operation_type (operation_type),
      .ula_entry      (ula_entry),
      .busy           (busy),
      .illegal        (illegal),
      .retired        (retired)
   );

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   // Absolute time limit so a stuck sequencer cannot hang the run
   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout, expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      compared++;
      if (actual !== expected) begin
         mismatched++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   function automatic void pushExpect(input string name, input int cycles,
                                      input logic [1:0] opUla, input logic ulaEntry,
                                      input logic opType, input logic isStore);
      expT e;
      e.name          = name;
      e.cycles        = cycles;
      e.opUla         = opUla;
      e.ulaEntry      = ulaEntry;
      e.opType        = opType;
      e.isStore       = isStore;
      e.retiredBefore = expRetired;
      scoreboard.push_back(e);
      expRetired = expRetired + (CNT_BITS+1)'(1);
   endfunction

   task automatic waitIrEn(input string name);
      int n = 0;
      @(negedge clk);
      while (!ir_en && n < 8) begin
         @(negedge clk);
         n++;
      end
      checkOutput({name, " ir_en"}, 32'(ir_en), 32'd1);
   endtask

   task automatic waitIdle(input string name, input int maxCycles);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (busy && n < maxCycles);
      checkOutput({name, " busy"}, 32'(busy), 32'd0);
   endtask

   // Runs one instruction from IDLE back to IDLE and checks the counter
   task automatic applyStimulus(input string name, input logic [31:0] instr,
                                input int cycles, input logic [1:0] opUla,
                                input logic ulaEntry, input logic opType,
                                input logic isStore);
      pushExpect(name, cycles, opUla, ulaEntry, opType, isStore);
      instrucao = instr;
      start     = 1'b1;
      waitIrEn({name, " start"});
      start = 1'b0;
      stop  = 1'b1;
      waitIdle({name, " done"}, 10);
      stop = 1'b0;
      checkOutput({name, " retired"}, 32'(retired), 32'(expRetired));
   endtask

   // Monitor: tracks cycles and write enables of the current instruction
   // and checks a scoreboard record on every completing (pc_en) cycle.
   always @(negedge clk) begin
      if (!reset) begin
         monCycles = 0;
         monLoads  = 0;
         monStores = 0;
      end else begin
         if (ir_en) begin
            monCycles = 1;
            monLoads  = 0;
            monStores = 0;
         end else if (busy) begin
            monCycles++;
         end
         if (load_en) monLoads++;
         if (store_en) monStores++;
         checkOutput("load/store exclusive", 32'(load_en & store_en), 32'd0);
         if (pc_en) begin
            if (scoreboard.size() == 0) begin
               checkOutput("unexpected completion", 32'd1, 32'd0);
            end else begin
               monExp = scoreboard.pop_front();
               checkOutput({monExp.name, " cycles"}, 32'(monCycles), 32'(monExp.cycles));
               checkOutput({monExp.name, " op_ula"}, 32'(op_ula), 32'(monExp.opUla));
               checkOutput({monExp.name, " ula_entry"}, 32'(ula_entry), 32'(monExp.ulaEntry));
               checkOutput({monExp.name, " operation_type"}, 32'(operation_type), 32'(monExp.opType));
               checkOutput({monExp.name, " load_en at pc_en"}, 32'(load_en), 32'(!monExp.isStore));
               checkOutput({monExp.name, " store_en at pc_en"}, 32'(store_en), 32'(monExp.isStore));
               checkOutput({monExp.name, " load pulses"}, 32'(monLoads), 32'(!monExp.isStore));
               checkOutput({monExp.name, " store pulses"}, 32'(monStores), 32'(monExp.isStore));
               checkOutput({monExp.name, " retired before"}, 32'(retired), 32'(monExp.retiredBefore));
            end
         end
      end
   end

   // Directed stimulus sequence
   initial begin
      int doneCount;
      int n;
      reset      = 1'b0;
      start      = 1'b0;
      stop       = 1'b0;
      instrucao  = 32'h0;
      expRetired = '0;
      repeat (2) @(negedge clk);

      $display("[TB] reset values");
      checkOutput("reset ir_en", 32'(ir_en), 32'd0);
      checkOutput("reset pc_en", 32'(pc_en), 32'd0);
      checkOutput("reset load_en", 32'(load_en), 32'd0);
      checkOutput("reset store_en", 32'(store_en), 32'd0);
      checkOutput("reset op_ula", 32'(op_ula), 32'd0);
      checkOutput("reset operation_type", 32'(operation_type), 32'd0);
      checkOutput("reset ula_entry", 32'(ula_entry), 32'd0);
      checkOutput("reset busy", 32'(busy), 32'd0);
      checkOutput("reset illegal", 32'(illegal), 32'd0);
      checkOutput("reset retired", 32'(retired), 32'd0);
      reset = 1'b1;

      $display("[TB] single instructions");
      applyStimulus("add",  I_ADD,  4, 2'b00, 1'b1, 1'b1, 1'b0);
      applyStimulus("ld",   I_LD,   5, 2'b00, 1'b0, 1'b0, 1'b0);
      applyStimulus("sd",   I_SD,   4, 2'b00, 1'b0, 1'b1, 1'b1);
      applyStimulus("sub",  I_SUB,  4, 2'b01, 1'b1, 1'b1, 1'b0);
      applyStimulus("slt",  I_SLT,  4, 2'b10, 1'b1, 1'b1, 1'b0);
      applyStimulus("equ",  I_EQU,  4, 2'b11, 1'b1, 1'b1, 1'b0);
      applyStimulus("addi", I_ADDI, 4, 2'b00, 1'b0, 1'b1, 1'b0);
      applyStimulus("subi", I_SUBI, 4, 2'b01, 1'b0, 1'b1, 1'b0);
      applyStimulus("slti", I_SLTI, 4, 2'b10, 1'b0, 1'b1, 1'b0);
      checkOutput("retired after nine", 32'(retired), 32'd9);

      $display("[TB] stop during EXEC, then start+stop in IDLE");
      pushExpect("addStop", 4, 2'b00, 1'b1, 1'b1, 1'b0);
      instrucao = I_ADD;
      start     = 1'b1;
      waitIrEn("addStop start");
      @(negedge clk);
      @(negedge clk);
      stop = 1'b1;
      waitIdle("addStop done", 10);
      checkOutput("addStop retired", 32'(retired), 32'd10);
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         checkOutput("start+stop idle", 32'({busy, ir_en}), 32'd0);
      end
      start = 1'b0;
      stop  = 1'b0;

      $display("[TB] back-to-back run through counter wrap");
      for (int i = 0; i < 6; i++) pushExpect("addRun", 4, 2'b00, 1'b1, 1'b1, 1'b0);
      instrucao = I_ADD;
      start     = 1'b1;
      doneCount = 0;
      n         = 0;
      while (doneCount < 5 && n < 60) begin
         @(negedge clk);
         n++;
         if (pc_en) doneCount++;
      end
      checkOutput("run completions", 32'(doneCount), 32'd5);
      @(negedge clk);
      start = 1'b0;
      stop  = 1'b1;
      waitIdle("run done", 10);
      stop = 1'b0;
      checkOutput("retired wrap", 32'(retired), 32'd0);

      $display("[TB] illegal instruction trap");
      instrucao = 32'h00000000;
      start     = 1'b1;
      waitIrEn("trap start");
      @(negedge clk);
      @(negedge clk);
      checkOutput("trap illegal", 32'(illegal), 32'd1);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         checkOutput("trap hold", 32'({ir_en, pc_en, load_en, store_en, busy, illegal}), 32'h01);
      end
      #1 reset = 1'b0;
      #1;
      checkOutput("trap reset illegal", 32'(illegal), 32'd0);
      checkOutput("trap reset busy", 32'(busy), 32'd0);
      start = 1'b0;
      @(negedge clk);
      reset      = 1'b1;
      expRetired = '0;

      $display("[TB] reset during MEM of sd");
      pushExpect("sdReset", 4, 2'b00, 1'b0, 1'b1, 1'b1);
      instrucao = I_SD;
      start     = 1'b1;
      waitIrEn("sdReset start");
      start = 1'b0;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      checkOutput("sdReset store_en in MEM", 32'(store_en), 32'd1);
      #1 reset = 1'b0;
      #1;
      checkOutput("sdReset store_en dropped", 32'(store_en), 32'd0);
      checkOutput("sdReset pc_en dropped", 32'(pc_en), 32'd0);
      checkOutput("sdReset busy", 32'(busy), 32'd0);
      checkOutput("sdReset retired", 32'(retired), 32'd0);
      @(negedge clk);
      reset      = 1'b1;
      expRetired = '0;
      @(negedge clk);
      checkOutput("sdReset idle", 32'({busy, ir_en, retired}), 32'd0);

      applyStimulus("addAfterReset", I_ADD, 4, 2'b00, 1'b1, 1'b1, 1'b0);
      checkOutput("retired after reset run", 32'(retired), 32'd1);

      checkOutput("scoreboard drained", 32'(scoreboard.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/unidade_controle.md
# unidade_controle

Multicycle control unit that drives the datapath's control inputs. Each instruction is fetched into the datapath's instruction register, then its opcode/funct3/funct7 fields are decoded. A state machine sequences fetch, decode, execute, memory and write-back, asserting `load_en`, `store_en`, `op_ula`, `operation_type` and `ula_entry` in the cycles each instruction needs. It also advances the program counter, counts retired instructions and traps on unsupported encodings.

## Interface
Parameters:
- `CNT_BITS`, 31: MSB index of the retired-instruction counter.

Ports:
- `clk`  in  1  single system clock, rising edge.
- `reset`  in  1  asynchronous, active-low; all state and outputs return to reset values immediately when low.
- `start`  in  1  level; in IDLE, begins execution at the current PC.
- `stop`  in  1  level; finish the current instruction, then return to IDLE.
- `instrucao`  in  32  instruction word from the datapath's instruction register; valid from DECODE onward.
- `ir_en`  out  1  load instruction register (FETCH only).
- `pc_en`  out  1  increment program counter (last cycle of each instruction).
- `load_en`  out  1  register-bank write enable.
- `store_en`  out  1  RAM write enable.
- `op_ula`  out  2  ALU op: 00 add, 01 sub, 10 slt, 11 equ.
- `operation_type`  out  1  register write source: 0 = memory, 1 = ALU.
- `ula_entry`  out  1  ALU operand 2: 0 = immediate, 1 = rs2.
- `busy`  out  1  high in every state except IDLE and TRAP.
- `illegal`  out  1  sticky; high in TRAP.
- `retired`  out  CNT_BITS+1  count of completed instructions.

## Operation
- Supported encodings (opcode / funct3 / funct7):
  - ld: 0000011 / 011
  - sd: 0100011 / 011
  - add: 0110011 / 000 / 0000000
  - sub: 0110011 / 000 / 0100000
  - slt: 0110011 / 010 / 0000000
  - equ: 0110011 / 100 / 0000000
  - addi: 0010011 / 000
  - subi: 0010011 / 001
  - slti: 0010011 / 010
- States: IDLE, FETCH, DECODE, EXEC, MEM, WB, TRAP.
- IDLE: all enables 0. `start`=1 and `stop`=0 → FETCH. If `start` and `stop` are both high, `stop` wins.
- FETCH: `ir_en`=1 → DECODE.
- DECODE: latch the decoded control word. Legal → EXEC; any other encoding → TRAP.
- EXEC: drive `op_ula`/`ula_entry`. ld/sd use add with imm. R-type uses `ula_entry`=1; I-type uses 0. ld/sd → MEM; otherwise → WB.
- MEM: ld → WB. sd: `store_en`=1 for exactly one cycle, `pc_en`=1, then go to the next state.
- WB: `load_en`=1, `pc_en`=1. `operation_type`=0 for ld, 1 otherwise. Then go to the next state.
- Next state after an instruction completes: `stop`=1 → IDLE, else FETCH. `stop` is sampled in the completing cycle.
- `op_ula`, `ula_entry` and `operation_type` are held stable from EXEC through the final cycle of the instruction.
- `retired` increments by 1 in each cycle where `pc_en`=1. It wraps from all-ones to 0.
- TRAP: all enables 0, `illegal`=1. Only `reset` exits TRAP; `start` is ignored.
- `reset` low in any state, including mid-instruction: go to IDLE immediately. A write enable that is high drops in the same instant.

## Timing
- Reset values: state IDLE; all enables 0; `op_ula`=00; `operation_type`=0; `ula_entry`=0; `busy`=0; `illegal`=0; `retired`=0.
- Outputs are Moore, decoded from registered state and the registered control word; no combinational path from `instrucao` to any output.
- Latency from `start` to the first `ir_en`: 1 cycle.
- Cycles per instruction: ld 5; sd 4; R-type and I-type 4.
- `pc_en` and `load_en`/`store_en` coincide in the final cycle of each instruction.
- `store_en` and `load_en` are never high in the same cycle.

## Structure
- Shared package `controle_pkg`:
  - opcode and funct3/funct7 constants
  - `op_ula` encodings
  - state encoding
  - packed control-word type `{op_ula, ula_entry, operation_type, is_mem, is_store, legal}`
- Sub-module `decodificador_instrucao`: purely combinational, 32-bit instruction in, control word out. The FSM registers its output in DECODE.

## Test plan
- add x3,x1,x2 (0x002081B3) after `start` → FETCH..WB in 4 cycles; `ula_entry`=1, `op_ula`=00, `operation_type`=1; `load_en`+`pc_en` in cycle 4; `retired`=1.
- ld x5,8(x1) (0x0080B283) → 5 cycles; `op_ula`=00, `ula_entry`=0; WB has `operation_type`=0 and `load_en`=1; `store_en` never high.
- sd x5,16(x2) (0x00513823) → 4 cycles; `store_en`=1 for exactly one cycle in MEM, together with `pc_en`; `load_en` never high.
- Instruction 0x00000000 → TRAP after DECODE; `illegal`=1 and all enables 0 for 10 cycles, even with `start`=1; `reset` low → `illegal`=0, IDLE.
- `stop` raised during EXEC of an add → that add completes (`retired` +1), then IDLE with `busy`=0. `start` and `stop` high together in IDLE → remains IDLE.
- `reset` pulsed low during MEM of sd → `store_en` drops immediately, `retired` unchanged from 0, state IDLE. Preloading `retired` to all-ones via a long run, then one more instruction → `retired` wraps to 0.
